// File: rtl/serial_word_tx_if.sv
// rtl/serial_word_tx_if.sv - word-in / bit-out handshake bundle for serial_word_tx
// The slave side is the transmitter; the master side supplies words and watches the serial stream.
interface serial_word_tx_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             bit_o;
  logic             sof_o;
  logic             eof_o;
  logic             bit_valid;
  logic             busy;

  modport master (
    output din, din_valid,
    input  din_ready, bit_o, sof_o, eof_o, bit_valid, busy
  );

  modport slave (
    input  din, din_valid,
    output din_ready, bit_o, sof_o, eof_o, bit_valid, busy
  );
endinterface

// File: rtl/serial_word_tx.sv
// rtl/serial_word_tx.sv - LSB-first bit-serial word transmitter with one-entry hold
// Words shift out one bit per clock; a held word follows the current one with no bubble.
module serial_word_tx #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_word_tx_if.slave sif
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic [CW-1:0]    r_cnt;
  logic             r_sof;
  logic             r_eof;
  logic             r_valid;

  logic             w_accept;
  logic             w_last;
  logic             w_free;
  logic             w_load_hold;
  logic             w_load_din;
  logic             w_load;
  logic [WIDTH-1:0] w_word;

  assign sif.din_ready = rst_n & ~r_hold_full;
  assign w_accept      = sif.din_valid & sif.din_ready;
  assign w_last        = (r_cnt == CW'(WIDTH - 1));
  // The shifter can take a new word when idle or when the last bit is on the line.
  assign w_free        = (r_state == S_IDLE) | w_last;
  assign w_load_hold   = r_hold_full & w_free;
  assign w_load_din    = ~r_hold_full & w_accept & w_free;
  assign w_load        = w_load_hold | w_load_din;
  assign w_word        = r_hold_full ? r_hold : sif.din;

  assign sif.bit_o     = r_shift[0];
  assign sif.sof_o     = r_sof;
  assign sif.eof_o     = r_eof;
  assign sif.bit_valid = r_valid;
  assign sif.busy      = (r_state == S_SHIFT) | r_hold_full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_cnt       <= '0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_valid     <= 1'b0;
    end else begin
      if (w_load) begin
        r_state <= S_SHIFT;
        r_shift <= w_word;
        r_cnt   <= '0;
        r_sof   <= 1'b1;
        r_eof   <= 1'b0;
        r_valid <= 1'b1;
      end else if (r_state == S_SHIFT && !w_last) begin
        r_shift <= r_shift >> 1;
        r_cnt   <= r_cnt + CW'(1);
        r_sof   <= 1'b0;
        r_eof   <= (r_cnt == CW'(WIDTH - 2));
      end else begin
        // Zeroing the shifter keeps bit_o low while idle.
        r_state <= S_IDLE;
        r_shift <= '0;
        r_cnt   <= '0;
        r_sof   <= 1'b0;
        r_eof   <= 1'b0;
        r_valid <= 1'b0;
      end

      if (w_load_hold) begin
        r_hold_full <= 1'b0;
      end else if (w_accept && !w_free) begin
        r_hold      <= sif.din;
        r_hold_full <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_serial_word_tx.sv
// tb/tb_serial_word_tx.sv - self-checking bench for serial_word_tx
// Reference keeps a queue of bits still to appear on the line; a word is ready-blocked while more than one word is queued.
module tb_serial_word_tx;
  localparam int W = 8;

  typedef struct packed {
    logic b;
    logic s;
    logic e;
  } bit_t;

  logic clk;
  logic rst_n;
  serial_word_tx_if #(.WIDTH(W)) sif ();

  serial_word_tx #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  bit_t q[$];

  logic [31:0] cap_word;
  logic [31:0] neg_word;
  logic [31:0] last_word;
  logic [31:0] last_neg;
  int          cap_n;
  bit          seen_one;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [W-1:0] d);
    bit   acc;
    bit_t cur;
    @(negedge clk);
    rst_n         = r;
    sif.din_valid = v;
    sif.din       = d;
    #1;
    if (chk_en) begin
      cur = (q.size() > 0) ? q[0] : '0;
      check("bit_valid", {31'd0, sif.bit_valid}, {31'd0, q.size() > 0});
      check("bit_o",     {31'd0, sif.bit_o},     {31'd0, cur.b});
      check("sof_o",     {31'd0, sif.sof_o},     {31'd0, cur.s});
      check("eof_o",     {31'd0, sif.eof_o},     {31'd0, cur.e});
      check("busy",      {31'd0, sif.busy},      {31'd0, q.size() > 0});
      check("din_ready", {31'd0, sif.din_ready}, {31'd0, r && (q.size() <= W)});
    end
    if (sif.bit_valid === 1'b1) begin
      if (sif.sof_o === 1'b1) begin
        cap_n    = 0;
        cap_word = '0;
        neg_word = '0;
        seen_one = 1'b0;
      end
      if (cap_n < 32) begin
        cap_word[cap_n] = sif.bit_o;
        neg_word[cap_n] = seen_one ? ~sif.bit_o : sif.bit_o;
      end
      seen_one = seen_one | sif.bit_o;
      cap_n++;
      if (sif.eof_o === 1'b1) begin
        last_word = cap_word;
        last_neg  = neg_word;
      end
    end
    @(posedge clk);
    if (!r) begin
      q.delete();
    end else begin
      acc = v && (q.size() <= W);
      if (q.size() > 0) void'(q.pop_front());
      if (acc) begin
        for (int i = 0; i < W; i++) begin
          q.push_back('{b: d[i], s: (i == 0), e: (i == W - 1)});
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, W'($urandom));
  endtask

  initial begin
    rst_n         = 1'b0;
    sif.din_valid = 1'b0;
    sif.din       = '0;
    cap_n         = 0;
    cap_word      = '0;
    neg_word      = '0;
    last_word     = '0;
    last_neg      = '0;
    seen_one      = 1'b0;

    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk_en = 1'b1;
    step(1'b0, 1'b1, 8'hAA);

    idle(20);

    step(1'b1, 1'b1, 8'hB4);
    idle(10);
    check("single_word", last_word, 32'h0000_00B4);

    step(1'b1, 1'b1, 8'h01);
    step(1'b1, 1'b1, 8'h80);
    idle(18);
    check("b2b_second", last_word, 32'h0000_0080);

    step(1'b1, 1'b1, 8'h3C);
    step(1'b1, 1'b1, 8'hC5);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, W'($urandom));
    step(1'b1, 1'b0, 8'h00);
    check("bp_held", last_word, 32'h0000_003C);
    idle(8);
    check("bp_held_next", last_word, 32'h0000_00C5);
    idle(12);

    step(1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 8'h0F);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h55);
    step(1'b1, 1'b0, 8'h00);
    check("rst_busy", {31'd0, sif.busy}, 32'd0);
    step(1'b1, 1'b1, 8'h02);
    idle(10);
    check("post_rst_word", last_word, 32'h0000_0002);

    step(1'b1, 1'b1, 8'h05);
    idle(10);
    check("neg_05", last_neg, 32'h0000_00FB);
    step(1'b1, 1'b1, 8'h00);
    idle(10);
    check("neg_00", last_neg, 32'h0000_0000);

    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] d;
      d = W'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        step(1'b0, $urandom_range(0, 1) == 1, d);
      end else if (i % 1000 < 500) begin
        step(1'b1, $urandom_range(0, 3) != 0, d);
      end else begin
        step(1'b1, $urandom_range(0, 7) == 0, d);
      end
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Bit-serial transmitter feeding the serial two's-complement negator. It is the source end of the same LSB-first serial interface.
- Accepts parallel words over a valid/ready handshake and shifts each word out LSB first, one bit per clock.
- Asserts a start-of-word marker on bit 0, which drives the negator's word-restart input directly.
- A one-entry holding register gives gapless back-to-back words.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- din  input  WIDTH  parallel word; bit 0 is transmitted first.
- din_valid  input  1  din holds a word to transfer.
- din_ready  output  1  block can accept a word this cycle.
- bit_o  output  1  serial data bit.
- sof_o  output  1  high with bit 0 of each word; connects to the negator's restart input.
- eof_o  output  1  high with bit WIDTH-1 of each word.
- bit_valid  output  1  bit_o carries a real word bit.
- busy  output  1  shifter active or holding register full.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - shifter, bit counter and holding register are cleared;
  - bit_o, sof_o, eof_o, bit_valid, busy all 0 from the next cycle;
  - din_ready is forced 0 combinationally while rst_n=0.
- Reset mid-word: the word in flight and any held word are discarded with no partial completion. The first word after reset starts with sof_o=1.
- din_ready = rst_n & ~hold_full. It is combinational and does not depend on din_valid.
- A word is accepted at an edge where din_valid & din_ready = 1.
- Outputs (bit_o, sof_o, eof_o, bit_valid) are registered:
  - a word accepted at edge k with the shifter free drives bit 0 in the cycle after edge k;
  - latency from acceptance to first bit is 1 cycle.
- State machine: IDLE, SHIFT. Internal count cnt runs 0..WIDTH-1 and equals the index of the bit currently on bit_o.
- IDLE, at each edge:
  - hold_full: load the shifter from hold, clear hold, go to SHIFT with cnt=0;
  - otherwise, if a word is accepted: load the shifter from din (bypass hold), go to SHIFT with cnt=0;
  - otherwise stay in IDLE.
  - In IDLE, bit_o=0, sof_o=0, eof_o=0, bit_valid=0.
- SHIFT, cnt < WIDTH-1, at each edge:
  - shift right one bit, cnt+1;
  - an accepted word goes into hold.
- SHIFT, cnt = WIDTH-1 (last bit, eof_o=1), at each edge, in priority order:
  - hold_full: load from hold, clear hold, cnt=0, stay in SHIFT;
  - word accepted this edge: load from din directly, cnt=0, stay in SHIFT;
  - otherwise go to IDLE.
  - These rules make consecutive words contiguous with no bubble.
- Same-edge case: hold_full and a new accept cannot coincide, because din_ready=0 whenever hold is full.
- In SHIFT, bit_valid=1. sof_o = (cnt==0). eof_o = (cnt==WIDTH-1).
- busy = (state==SHIFT) | hold_full.
- Sustained rate: one word per WIDTH cycles with no gaps.
  - Hold fills during the first cycle of a word, so din_ready drops for WIDTH-1 cycles, then rises in the cycle after hold drains.
- din is sampled only at the acceptance edge. Later changes to din do not affect the word in flight or the held word.
- Without a handshake no word is produced, and din_valid held high is harmless.

Test Plan:
- Single word, WIDTH=8: din=8'hB4, one-cycle valid from reset-idle.
  - Next 8 cycles: bit_o=0,0,1,0,1,1,0,1; bit_valid=1 throughout.
  - sof_o=1 on cycle 1 only; eof_o=1 on cycle 8 only.
  - Then IDLE, all outputs 0.
- Back-to-back: din_valid held high with 8'h01, then 8'h80 presented after the first accept.
  - 16 contiguous bit_valid cycles; bits = 1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1.
  - sof_o on cycles 1 and 9; eof_o on cycles 8 and 16.
  - din_ready low while hold is full.
- Backpressure: with hold full, drive din_valid=1 and change din each cycle.
  - No additional word is accepted.
  - The held value, not the later din values, is transmitted next.
- Reset mid-word: 8'hFF accepted, plus 8'h0F in hold; assert rst_n=0 at bit 3.
  - Next cycle: all outputs 0, busy=0.
  - After release, a new word 8'h02 yields bits 0,1,0,0,0,0,0,0 with sof_o on the first bit.
- Chained with the negator (sof_o to its restart input): din=8'h05.
  - Negator output bits over the 8 word cycles = 1,1,0,1,1,1,1,1 (8'hFB).
  - din=8'h00 yields all-zero output.
- Idle hold: din_valid=0 for 20 cycles after reset.
  - bit_valid, sof_o, eof_o, busy stay 0; din_ready stays 1.
